// File: rtl/despertador_pkg.sv
// Shared types, constants and helpers for the alarm-clock timekeeping and
// digit-display sequencer.
package despertador_pkg;

  // Display sweep states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_DONE = 2'd2
  } sweep_state_t;

  // Digit slave indices, in sweep order (chipselect bit = index)
  localparam logic [2:0] DIG_HORA1 = 3'd0;
  localparam logic [2:0] DIG_HORA0 = 3'd1;
  localparam logic [2:0] DIG_MIN1  = 3'd2;
  localparam logic [2:0] DIG_MIN0  = 3'd3;
  localparam logic [2:0] DIG_SEG1  = 3'd4;
  localparam logic [2:0] DIG_SEG0  = 3'd5;

  // BCD upper limits for hours and minutes/seconds
  localparam logic [7:0] BCD_HH_MAX = 8'h23;
  localparam logic [7:0] BCD_MS_MAX = 8'h59;

  // gfedcba pattern for one BCD digit; non-decimal codes show a blank digit
  function automatic logic [6:0] seg7_encode(input logic [3:0] digit,
                                             input logic       active_low);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h00;
    endcase
    return active_low ? ~pat : pat;
  endfunction

  // True when both nibbles are decimal and the value does not exceed lim
  function automatic logic bcd_in_range(input logic [7:0] v,
                                        input logic [7:0] lim);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= lim);
  endfunction

endpackage

// File: rtl/despertador_bcd_counter.sv
// Two-nibble BCD counter that wraps to 00 after MAX_VAL. Load has priority
// over increment; carry_o flags the increment that wraps.
module despertador_bcd_counter #(
  parameter logic [7:0] MAX_VAL = 8'h59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] value_o,
  output logic       carry_o
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  // Next value: load, else per-nibble BCD increment with wrap at MAX_VAL
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (inc_i) begin
      if (value_q == MAX_VAL) begin
        value_d = 8'h00;
      end else if (value_q[3:0] == 4'd9) begin
        value_d = {value_q[7:4] + 4'd1, 4'd0};
      end else begin
        value_d = {value_q[7:4], value_q[3:0] + 4'd1};
      end
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= 8'h00;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  assign carry_o = inc_i && !load_i && (value_q == MAX_VAL);

endmodule

// File: rtl/despertador_time_pio_sequencer.sv
// Alarm-clock timekeeper: BCD HH:MM:SS from a 1 Hz tick, validated time
// loads, alarm match pulse, and an Avalon-MM write sweep that pushes the six
// seven-segment digit patterns into their PIO slaves whenever time changes.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no write in flight; waits for dirty, then snapshots the digits
// ST_WR   | write of digit idx asserted; held while m_waitrequest is high
// ST_DONE | one cycle with strobes released before returning to ST_IDLE
module despertador_time_pio_sequencer
  import despertador_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int NUM_DIGITS     = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_1hz,
  input  logic                  load_valid,
  input  logic [7:0]            load_hh,
  input  logic [7:0]            load_mm,
  input  logic                  alarm_en,
  input  logic [7:0]            alarm_hh,
  input  logic [7:0]            alarm_mm,
  input  logic                  m_waitrequest,
  output logic [NUM_DIGITS-1:0] m_chipselect,
  output logic [1:0]            m_address,
  output logic                  m_write_n,
  output logic [31:0]           m_writedata,
  output logic [7:0]            time_hh,
  output logic [7:0]            time_mm,
  output logic [7:0]            time_ss,
  output logic                  busy,
  output logic                  alarm_hit,
  output logic                  load_err
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  logic       load_ok;
  logic       load_apply;
  logic       tick_apply;
  logic       time_chg;
  logic       ss_carry;
  logic       mm_carry;
  logic       hh_carry;
  logic       alarm_ok;
  logic [7:0] hh_val;
  logic [7:0] mm_val;
  logic [7:0] ss_val;

  // A load in the same cycle as a tick wins, even when the load is rejected
  assign load_ok    = bcd_in_range(load_hh, BCD_HH_MAX) &&
                      bcd_in_range(load_mm, BCD_MS_MAX);
  assign load_apply = load_valid && load_ok;
  assign tick_apply = tick_1hz && !load_valid;
  assign time_chg   = load_apply || tick_apply || hh_carry;

  despertador_bcd_counter #(.MAX_VAL(BCD_MS_MAX)) u_ss (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (tick_apply),
    .load_i     (load_apply),
    .load_val_i (8'h00),
    .value_o    (ss_val),
    .carry_o    (ss_carry)
  );

  despertador_bcd_counter #(.MAX_VAL(BCD_MS_MAX)) u_mm (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (ss_carry),
    .load_i     (load_apply),
    .load_val_i (load_mm),
    .value_o    (mm_val),
    .carry_o    (mm_carry)
  );

  despertador_bcd_counter #(.MAX_VAL(BCD_HH_MAX)) u_hh (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (mm_carry),
    .load_i     (load_apply),
    .load_val_i (load_hh),
    .value_o    (hh_val),
    .carry_o    (hh_carry)
  );

  assign time_hh = hh_val;
  assign time_mm = mm_val;
  assign time_ss = ss_val;

  // ------------------------------------------------------------------
  // Alarm and load error pulses. tick_seen_q marks the cycle in which the
  // counters show a tick-produced time, so loads never trigger the alarm.
  // ------------------------------------------------------------------
  logic tick_seen_q;
  logic alarm_hit_q;
  logic load_err_q;

  assign alarm_ok = bcd_in_range(alarm_hh, BCD_HH_MAX) &&
                    bcd_in_range(alarm_mm, BCD_MS_MAX);

  // Registered one-cycle status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_seen_q <= 1'b0;
      alarm_hit_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      tick_seen_q <= tick_apply;
      alarm_hit_q <= tick_seen_q && alarm_en && alarm_ok &&
                     (hh_val == alarm_hh) && (mm_val == alarm_mm) &&
                     (ss_val == 8'h00);
      load_err_q  <= load_valid && !load_ok;
    end
  end

  assign alarm_hit = alarm_hit_q;
  assign load_err  = load_err_q;

  // ------------------------------------------------------------------
  // Dirty flag: set by any time change, cleared when IDLE takes a snapshot.
  // A change in the snapshot cycle keeps dirty set so it is not lost.
  // ------------------------------------------------------------------
  sweep_state_t state_q;
  logic         dirty_q;
  logic         snap_take;

  assign snap_take = (state_q == ST_IDLE) && dirty_q;

  // Pending-display-update flag
  always_ff @(posedge clk) begin
    if (reset) begin
      dirty_q <= 1'b1;
    end else begin
      dirty_q <= (dirty_q && !snap_take) || time_chg;
    end
  end

  // ------------------------------------------------------------------
  // Display sweep
  // ------------------------------------------------------------------
  logic [NUM_DIGITS-1:0][3:0] live_digits;
  logic [NUM_DIGITS-1:0][3:0] snap_q;
  logic [2:0]                 idx_q;
  logic [2:0]                 next_idx;
  logic [NUM_DIGITS-1:0]      cs_q;
  logic                       write_n_q;
  logic [6:0]                 wdata_q;
  logic                       busy_q;

  assign live_digits[DIG_HORA1] = hh_val[7:4];
  assign live_digits[DIG_HORA0] = hh_val[3:0];
  assign live_digits[DIG_MIN1]  = mm_val[7:4];
  assign live_digits[DIG_MIN0]  = mm_val[3:0];
  assign live_digits[DIG_SEG1]  = ss_val[7:4];
  assign live_digits[DIG_SEG0]  = ss_val[3:0];

  assign next_idx = idx_q + 3'd1;

  // Sweep FSM with registered bus strobes; writes come only from the snapshot
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      snap_q    <= '0;
      idx_q     <= 3'd0;
      cs_q      <= '0;
      write_n_q <= 1'b1;
      wdata_q   <= 7'h00;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dirty_q) begin
            snap_q    <= live_digits;
            idx_q     <= 3'd0;
            cs_q      <= {{(NUM_DIGITS-1){1'b0}}, 1'b1};
            write_n_q <= 1'b0;
            wdata_q   <= seg7_encode(live_digits[DIG_HORA1], SEG_ACTIVE_LOW);
            busy_q    <= 1'b1;
            state_q   <= ST_WR;
          end
        end
        ST_WR: begin
          if (!m_waitrequest) begin
            if (idx_q == LAST_IDX) begin
              cs_q      <= '0;
              write_n_q <= 1'b1;
              wdata_q   <= 7'h00;
              state_q   <= ST_DONE;
            end else begin
              idx_q   <= next_idx;
              cs_q    <= cs_q << 1;
              wdata_q <= seg7_encode(snap_q[next_idx], SEG_ACTIVE_LOW);
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          cs_q      <= '0;
          write_n_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_chipselect = cs_q;
  assign m_address    = 2'b00;
  assign m_write_n    = write_n_q;
  assign m_writedata  = {25'd0, wdata_q};
  assign busy         = busy_q;

endmodule

// File: tb/tb_despertador_time_pio_sequencer.sv
// Scoreboard bench for the alarm-clock time / PIO sweep sequencer.
module tb_despertador_time_pio_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick_1hz = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_hh = 8'h00;
  logic [7:0]  load_mm = 8'h00;
  logic        alarm_en = 1'b0;
  logic [7:0]  alarm_hh = 8'h00;
  logic [7:0]  alarm_mm = 8'h00;
  logic        m_waitrequest = 1'b0;
  logic [5:0]  m_chipselect;
  logic [1:0]  m_address;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic [7:0]  time_hh;
  logic [7:0]  time_mm;
  logic [7:0]  time_ss;
  logic        busy;
  logic        alarm_hit;
  logic        load_err;

  int total = 0;
  int bad = 0;
  int model_h = 0;
  int model_m = 0;
  int model_s = 0;
  int al_h = 0;
  int al_m = 0;
  int alarm_pulses = 0;

  typedef struct packed {
    logic [5:0]  cs;
    logic [31:0] data;
  } wr_t;
  wr_t sbq[$];

  // Inverted (active-low) gfedcba patterns for digits 0..9
  logic [6:0] seg_lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  despertador_time_pio_sequencer #(.SEG_ACTIVE_LOW(1'b1), .NUM_DIGITS(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .tick_1hz      (tick_1hz),
    .load_valid    (load_valid),
    .load_hh       (load_hh),
    .load_mm       (load_mm),
    .alarm_en      (alarm_en),
    .alarm_hh      (alarm_hh),
    .alarm_mm      (alarm_mm),
    .m_waitrequest (m_waitrequest),
    .m_chipselect  (m_chipselect),
    .m_address     (m_address),
    .m_write_n     (m_write_n),
    .m_writedata   (m_writedata),
    .time_hh       (time_hh),
    .time_mm       (time_mm),
    .time_ss       (time_ss),
    .busy          (busy),
    .alarm_hit     (alarm_hit),
    .load_err      (load_err)
  );

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_sweep();
    int  d[6];
    wr_t e;
    d[0] = model_h / 10; d[1] = model_h % 10;
    d[2] = model_m / 10; d[3] = model_m % 10;
    d[4] = model_s / 10; d[5] = model_s % 10;
    for (int i = 0; i < 6; i++) begin
      e.cs   = 6'(1 << i);
      e.data = {25'd0, seg_lut[d[i]]};
      sbq.push_back(e);
    end
  endtask

  task automatic model_advance();
    model_s++;
    if (model_s == 60) begin
      model_s = 0;
      model_m++;
      if (model_m == 60) begin
        model_m = 0;
        model_h++;
        if (model_h == 24) model_h = 0;
      end
    end
  endtask

  task automatic check_time(input string tag);
    check({tag, "_hh"}, 32'(time_hh), 32'(to_bcd(model_h)));
    check({tag, "_mm"}, 32'(time_mm), 32'(to_bcd(model_m)));
    check({tag, "_ss"}, 32'(time_ss), 32'(to_bcd(model_s)));
  endtask

  // Wait until every expected write has been seen and the sweep has gone quiet
  task automatic drain();
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 400) begin
      @(negedge clk); #2;
      n++;
      if (!busy && sbq.size() == 0) quiet++;
      else quiet = 0;
    end
    check("drain_queue_empty", 32'(sbq.size()), 32'd0);
    check("drain_busy_low", 32'(busy), 32'd0);
  endtask

  task automatic do_tick();
    logic exp_hit;
    @(negedge clk);
    tick_1hz = 1'b1;
    model_advance();
    push_sweep();
    exp_hit = alarm_en && (model_h == al_h) && (model_m == al_m) && (model_s == 0);
    @(negedge clk);
    tick_1hz = 1'b0;
    #2;
    check_time("tick");
    check("alarm_not_early", 32'(alarm_hit), 32'd0);
    @(negedge clk); #2;
    check("alarm_hit_timing", 32'(alarm_hit), 32'(exp_hit));
    drain();
  endtask

  task automatic do_load(input logic [7:0] hh, input logic [7:0] mm,
                         input logic with_tick, input logic expect_ok);
    @(negedge clk);
    load_valid = 1'b1;
    load_hh    = hh;
    load_mm    = mm;
    tick_1hz   = with_tick;
    if (expect_ok) begin
      model_h = from_bcd(hh);
      model_m = from_bcd(mm);
      model_s = 0;
      push_sweep();
    end
    @(negedge clk);
    load_valid = 1'b0;
    tick_1hz   = 1'b0;
    #2;
    check("load_err_pulse", 32'(load_err), 32'(!expect_ok));
    check_time("load");
    @(negedge clk); #2;
    check("load_err_single", 32'(load_err), 32'd0);
  endtask

  // Monitor: every accepted write is compared against the scoreboard head
  initial begin
    wr_t e;
    forever begin
      @(negedge clk); #1;
      if (!reset && !m_write_n && !m_waitrequest) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write cs=%0h data=%0h required=none", m_chipselect, m_writedata);
        end else begin
          e = sbq.pop_front();
          check("wr_chipselect", 32'(m_chipselect), 32'(e.cs));
          check("wr_writedata", m_writedata, e.data);
          check("wr_address", 32'(m_address), 32'd0);
        end
      end
      if (!reset && alarm_hit) alarm_pulses++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int  found;
    int  pulses0;
    int  busy_seen;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_chipselect", 32'(m_chipselect), 32'd0);
    check("rst_write_n", 32'(m_write_n), 32'd1);
    check("rst_writedata", m_writedata, 32'd0);
    check("rst_address", 32'(m_address), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alarm_hit", 32'(alarm_hit), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check_time("rst");

    // Release: sweep of 00:00:00 starts on the first cycle out of reset
    @(negedge clk);
    reset = 1'b0;
    model_h = 0; model_m = 0; model_s = 0;
    push_sweep();
    @(negedge clk); #2;
    check("first_write_cs", 32'(m_chipselect), 32'h01);
    check("first_write_n", 32'(m_write_n), 32'd0);
    check("first_write_busy", 32'(busy), 32'd1);
    drain();

    // 23:59:00 plus 60 ticks wraps the day
    do_load(8'h23, 8'h59, 1'b0, 1'b1);
    drain();
    for (int i = 0; i < 60; i++) do_tick();
    check("wrap_hh", 32'(time_hh), 32'h00);
    check("wrap_mm", 32'(time_mm), 32'h00);
    check("wrap_ss", 32'(time_ss), 32'h00);

    // Invalid loads: error pulse, time untouched, no sweep
    do_load(8'h24, 8'h10, 1'b0, 1'b0);
    do_load(8'h12, 8'h60, 1'b1, 1'b0);
    do_load(8'h0A, 8'h00, 1'b0, 1'b0);
    busy_seen = 0;
    repeat (6) begin
      @(negedge clk); #2;
      if (busy) busy_seen = 1;
    end
    check("bad_load_no_sweep", 32'(busy_seen), 32'd0);
    check_time("bad_load");

    // Alarm 07:30 enabled: single pulse after the tick into 07:30:00
    alarm_hh = 8'h07; alarm_mm = 8'h30; al_h = 7; al_m = 30;
    alarm_en = 1'b1;
    do_load(8'h07, 8'h29, 1'b0, 1'b1);
    drain();
    pulses0 = alarm_pulses;
    for (int i = 0; i < 60; i++) do_tick();
    check("alarm_en_pulses", 32'(alarm_pulses - pulses0), 32'd1);
    check("alarm_time_hh", 32'(time_hh), 32'h07);
    check("alarm_time_mm", 32'(time_mm), 32'h30);

    // Load landing exactly on the alarm time does not fire
    pulses0 = alarm_pulses;
    do_load(8'h07, 8'h30, 1'b0, 1'b1);
    drain();
    check("alarm_load_no_pulse", 32'(alarm_pulses - pulses0), 32'd0);

    // Alarm disabled: no pulse
    alarm_en = 1'b0;
    do_load(8'h07, 8'h29, 1'b0, 1'b1);
    drain();
    pulses0 = alarm_pulses;
    for (int i = 0; i < 60; i++) do_tick();
    check("alarm_dis_pulses", 32'(alarm_pulses - pulses0), 32'd0);

    // Stall at idx 2 for 3 cycles with a tick arriving during the stall
    do_load(8'h08, 8'h15, 1'b0, 1'b1);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!m_write_n && m_chipselect == 6'h04) begin
        found = 1;
        break;
      end
    end
    check("stall_reached_idx2", 32'(found), 32'd1);
    if (found == 1) begin
      m_waitrequest = 1'b1;
      tick_1hz = 1'b1;
      model_advance();
      push_sweep();
      #2;
      check("stall_cs_c0", 32'(m_chipselect), 32'h04);
      check("stall_data_c0", m_writedata, 32'h79);
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        tick_1hz = 1'b0;
        if (c == 3) m_waitrequest = 1'b0;
        #2;
        check("stall_cs_hold", 32'(m_chipselect), 32'h04);
        check("stall_data_hold", m_writedata, 32'h79);
        check("stall_write_n_hold", 32'(m_write_n), 32'd0);
      end
      check_time("stall_tick");
    end
    m_waitrequest = 1'b0;
    tick_1hz = 1'b0;
    drain();

    // Load and tick together: load wins, tick dropped
    do_load(8'h12, 8'h00, 1'b1, 1'b1);
    drain();
    check("load_tick_ss", 32'(time_ss), 32'h00);
    check("load_tick_hh", 32'(time_hh), 32'h12);

    // Reset in the middle of a sweep aborts it and restarts from 00:00:00
    do_load(8'h10, 8'h00, 1'b0, 1'b1);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!m_write_n && m_chipselect == 6'h08) begin
        found = 1;
        break;
      end
    end
    check("midsweep_reached_idx3", 32'(found), 32'd1);
    reset = 1'b1;
    sbq.delete();
    @(negedge clk); #2;
    check("midrst_chipselect", 32'(m_chipselect), 32'd0);
    check("midrst_write_n", 32'(m_write_n), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    model_h = 0; model_m = 0; model_s = 0;
    check_time("midrst");
    @(negedge clk);
    reset = 1'b0;
    push_sweep();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/despertador_time_pio_sequencer.md
Name: despertador_time_pio_sequencer

Overview:
Timekeeping and display-update controller for the alarm clock. Maintains BCD HH:MM:SS from a 1 Hz tick, accepts time loads, and raises an alarm-hit pulse. Sequences Avalon-MM writes into the six 7-bit digit PIO slaves (hora1, hora0, min1, min0, seg1, seg0), so software no longer writes the digit registers.

Parameters:
SEG_ACTIVE_LOW, 1, 1 = segment patterns inverted (board segments light on 0); 0 = gfedcba active-high.
NUM_DIGITS, 6, number of digit PIO slaves in the sweep; fixed at 6 for HH:MM:SS.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick_1hz  in  1  one-cycle pulse, advances time by 1 s
load_valid  in  1  one-cycle request to load time
load_hh  in  8  BCD hours for load
load_mm  in  8  BCD minutes for load (seconds load as 00)
alarm_en  in  1  alarm compare enable
alarm_hh  in  8  BCD alarm hours
alarm_mm  in  8  BCD alarm minutes
m_waitrequest  in  1  slave stall; hold the current write while high
m_chipselect  out  6  one-hot digit slave select (bit0 = hora1 ... bit5 = seg0)
m_address  out  2  always 0 (PIO data register)
m_write_n  out  1  active-low write strobe
m_writedata  out  32  {25'b0, seg7 pattern}
time_hh, time_mm, time_ss  out  8 each  current BCD time
busy  out  1  sweep in progress
alarm_hit  out  1  one-cycle pulse on alarm match
load_err  out  1  one-cycle pulse, invalid load rejected

Behaviour:
- Reset (sync, one cycle is enough): time = 00:00:00; m_chipselect = 0, m_write_n = 1, m_writedata = 0, m_address = 0, busy = 0, alarm_hit = 0, load_err = 0; dirty = 1, so the first sweep after reset shows 00:00:00.
- Time counting on tick_1hz:
  - ss 00..59, carry into mm 00..59, carry into hh 00..23.
  - 23:59:59 wraps to 00:00:00.
  - Counting is per BCD nibble; the units nibble wraps at 9.
- Load:
  - Valid only if every nibble is <= 9, hh <= 0x23 and mm <= 0x59.
  - Valid load: hh/mm take the load values and ss = 00 on the next edge.
  - Invalid load: time unchanged, load_err pulses for one cycle.
  - load_valid and tick_1hz in the same cycle: the load wins and the tick is dropped. This also holds for an invalid load (error pulse, tick still dropped).
- Any change to the time (tick or valid load) sets dirty.
- Alarm: alarm_hit pulses for one cycle, in the cycle after the time becomes alarm_hh:alarm_mm:00 via tick, when alarm_en = 1.
  - A load that lands exactly on the alarm time does not fire.
  - Out-of-range alarm values never match.
- Sweep FSM:
  - IDLE: when dirty = 1, snapshot the six digits, clear dirty, go to WR with idx = 0.
  - WR: m_chipselect = 1 << idx, m_write_n = 0, m_writedata = seg7(digit[idx]). Hold these while m_waitrequest = 1. When m_waitrequest = 0, the write completes that cycle: idx++. After idx = 5 completes, go to DONE.
  - DONE: one cycle with all strobes deasserted, then IDLE. busy = 1 in WR and DONE.
- Sweep timing:
  - With no stalls, the first write is asserted the cycle after dirty is set.
  - A sweep is 6 write cycles plus DONE.
  - A time change during a sweep does not alter the in-flight snapshot. It sets dirty, so a fresh sweep starts from idx 0 after DONE. No writes are lost or torn.
- seg7 patterns (active-high gfedcba): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. Inverted when SEG_ACTIVE_LOW = 1 (e.g. 0 -> 0x40).
- Reset asserted mid-sweep aborts the sweep immediately; the sequence restarts per the reset rules.

Decomposition:
- despertador_pkg holds:
  - FSM state enum {IDLE, WR, DONE}
  - digit index constants DIG_HORA1..DIG_SEG0
  - BCD limit constants (0x23, 0x59)
  - seg7 encode function
- Natural sub-module: despertador_bcd_counter, a two-nibble BCD counter parameterised by its max value, with inc, load and carry out. Instantiated for ss, mm and hh.

Test Plan:
- Reset, then release with waitrequest = 0 -> six consecutive writes on chipselect 0x01..0x20, each writedata = 0x40, then busy falls after DONE.
- Load 0x23 / 0x59, drain the sweep, apply 60 ticks -> time 00:00:00 after the last tick; final sweep writes 0x40 x6.
- Load 0x24 / 0x10 -> load_err pulses once, time unchanged, no sweep starts.
- alarm 07:30, alarm_en = 1, load 07:29, 60 ticks -> alarm_hit single pulse one cycle after time reaches 07:30:00. Repeat with alarm_en = 0 -> no pulse.
- waitrequest held high 3 cycles during idx 2 -> chipselect 0x04 and writedata stable for 4 cycles; a tick during the stall completes the old sweep, then a new sweep begins from chipselect 0x01.
- load_valid and tick_1hz in the same cycle (load 12:00) -> time 12:00:00, not 12:00:01.
